// File: rtl/avmm_rw_responder.sv
// Avalon-MM responder backed by a word-addressed RAM: byte-enabled writes,
// fixed-latency pipelined reads, no waitrequest, saturating debug statistics.
module avmm_rw_responder #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1,
  parameter logic [63:0] BASE_ADDR    = 64'h0,
  parameter logic [63:0] OOB_DATA     = 64'hDEAD_BEEF_DEAD_BEEF
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [63:0] avmm_address,
  input  logic [7:0]  avmm_byteenable,
  input  logic        avmm_read,
  output logic [63:0] avmm_readdata,
  input  logic        avmm_write,
  input  logic [63:0] avmm_writedata,
  output logic        rsp_valid,
  input  logic        clear_stats,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
  output logic [15:0] oob_count,
  output logic        proto_err
);

  // Handshake: there is no backpressure. A request (avmm_read or avmm_write high)
  // is accepted in the cycle it is presented. Each accepted read produces exactly
  // one rsp_valid pulse READ_LATENCY cycles later, together with the avmm_readdata
  // update; avmm_readdata then holds until the next pulse. A cycle with both
  // read and write high is a protocol error: the write wins, the read is dropped.

  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned PIPE_D = READ_LATENCY - 1;

  // ---------------------------------------------------------------------------
  // Address decode. BASE_ADDR is word aligned, so the subtraction is done on
  // word addresses directly and the byte offset bits are simply ignored.
  // ---------------------------------------------------------------------------
  logic [60:0]      word_off;
  logic             below_base;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             unused_addr_lsbs;

  assign word_off         = avmm_address[63:3] - BASE_ADDR[63:3];
  assign below_base       = (avmm_address < BASE_ADDR);
  assign in_range         = !below_base && (word_off < 61'(DEPTH_WORDS));
  assign idx              = word_off[IDX_W-1:0];
  assign unused_addr_lsbs = ^avmm_address[2:0];

  logic rd_accept;
  logic wr_accept;
  logic both_req;

  assign rd_accept = avmm_read && !avmm_write;
  assign wr_accept = avmm_write;
  assign both_req  = avmm_read && avmm_write;

  // ---------------------------------------------------------------------------
  // Read pipe: carries (valid, idx, oob) so the RAM is only looked up at exit.
  // ---------------------------------------------------------------------------
  logic             exit_v;
  logic [IDX_W-1:0] exit_idx;
  logic             exit_oob;

  generate
    if (READ_LATENCY == 1) begin : g_direct
      assign exit_v   = rd_accept;
      assign exit_idx = idx;
      assign exit_oob = !in_range;
    end else begin : g_pipe
      logic             pv_q   [PIPE_D];
      logic             pv_d   [PIPE_D];
      logic [IDX_W-1:0] pidx_q [PIPE_D];
      logic [IDX_W-1:0] pidx_d [PIPE_D];
      logic             poob_q [PIPE_D];
      logic             poob_d [PIPE_D];

      // Shift requests one stage per cycle; stage 0 takes the new request.
      always_comb begin
        pv_d[0]   = rd_accept;
        pidx_d[0] = idx;
        poob_d[0] = !in_range;
        for (int s = 1; s < PIPE_D; s++) begin
          pv_d[s]   = pv_q[s-1];
          pidx_d[s] = pidx_q[s-1];
          poob_d[s] = poob_q[s-1];
        end
      end

      // Pipe registers; reset flushes any in-flight read.
      always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
          for (int s = 0; s < PIPE_D; s++) begin
            pv_q[s]   <= 1'b0;
            pidx_q[s] <= '0;
            poob_q[s] <= 1'b0;
          end
        end else begin
          for (int s = 0; s < PIPE_D; s++) begin
            pv_q[s]   <= pv_d[s];
            pidx_q[s] <= pidx_d[s];
            poob_q[s] <= poob_d[s];
          end
        end
      end

      assign exit_v   = pv_q[PIPE_D-1];
      assign exit_idx = pidx_q[PIPE_D-1];
      assign exit_oob = poob_q[PIPE_D-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // RAM (contents are not reset).
  // ---------------------------------------------------------------------------
  logic [63:0] mem [DEPTH_WORDS];

  // Byte-lane write of in-range requests.
  always_ff @(posedge clock) begin
    if (wr_accept && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (avmm_byteenable[i]) mem[idx][8*i +: 8] <= avmm_writedata[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Response and statistics.
  // ---------------------------------------------------------------------------
  logic [63:0] rd_word;
  logic [63:0] readdata_d, readdata_q;
  logic        rsp_valid_d, rsp_valid_q;
  logic [31:0] rd_count_d, rd_count_q;
  logic [31:0] wr_count_d, wr_count_q;
  logic [15:0] oob_count_d, oob_count_q;
  logic        proto_err_d, proto_err_q;

  // Exiting read data, with a same-cycle write to that word merged in (write-first).
  always_comb begin
    rd_word = mem[exit_idx];
    if (wr_accept && in_range && (idx == exit_idx)) begin
      for (int i = 0; i < 8; i++) begin
        if (avmm_byteenable[i]) rd_word[8*i +: 8] = avmm_writedata[8*i +: 8];
      end
    end
  end

  // Next response and next statistics; clear_stats overrides any increment.
  always_comb begin
    readdata_d  = readdata_q;
    rsp_valid_d = 1'b0;
    if (exit_v) begin
      rsp_valid_d = 1'b1;
      readdata_d  = exit_oob ? OOB_DATA : rd_word;
    end

    rd_count_d  = rd_count_q;
    wr_count_d  = wr_count_q;
    oob_count_d = oob_count_q;
    proto_err_d = proto_err_q;
    if (rd_accept && (rd_count_q != '1)) rd_count_d = rd_count_q + 32'd1;
    if (wr_accept && (wr_count_q != '1)) wr_count_d = wr_count_q + 32'd1;
    if ((rd_accept || wr_accept) && !in_range && (oob_count_q != '1))
      oob_count_d = oob_count_q + 16'd1;
    if (both_req) proto_err_d = 1'b1;
    if (clear_stats) begin
      rd_count_d  = '0;
      wr_count_d  = '0;
      oob_count_d = '0;
      proto_err_d = 1'b0;
    end
  end

  // Output and statistics registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      readdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      oob_count_q <= '0;
      proto_err_q <= 1'b0;
    end else begin
      readdata_q  <= readdata_d;
      rsp_valid_q <= rsp_valid_d;
      rd_count_q  <= rd_count_d;
      wr_count_q  <= wr_count_d;
      oob_count_q <= oob_count_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign avmm_readdata = readdata_q;
  assign rsp_valid     = rsp_valid_q;
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;
  assign oob_count     = oob_count_q;
  assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_avmm_rw_responder.sv
// Bench for avmm_rw_responder: directed traffic, a transaction-level memory
// model checked every cycle, and literal expectations for the key results.
module tb_avmm_rw_responder;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LAT     = 3;
  localparam logic [63:0] BASE    = 64'h0;
  localparam logic [63:0] OOB_VAL = 64'hDEAD_BEEF_DEAD_BEEF;

  logic        clock;
  logic        resetn;
  logic [63:0] avmm_address;
  logic [7:0]  avmm_byteenable;
  logic        avmm_read;
  logic [63:0] avmm_readdata;
  logic        avmm_write;
  logic [63:0] avmm_writedata;
  logic        rsp_valid;
  logic        clear_stats;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
  logic [15:0] oob_count;
  logic        proto_err;

  int tests = 0;
  int fails = 0;

  avmm_rw_responder #(
    .DEPTH_WORDS (DEPTH),
    .READ_LATENCY(LAT),
    .BASE_ADDR   (BASE),
    .OOB_DATA    (OOB_VAL)
  ) dut (
    .clock          (clock),
    .resetn         (resetn),
    .avmm_address   (avmm_address),
    .avmm_byteenable(avmm_byteenable),
    .avmm_read      (avmm_read),
    .avmm_readdata  (avmm_readdata),
    .avmm_write     (avmm_write),
    .avmm_writedata (avmm_writedata),
    .rsp_valid      (rsp_valid),
    .clear_stats    (clear_stats),
    .rd_count       (rd_count),
    .wr_count       (wr_count),
    .oob_count      (oob_count),
    .proto_err      (proto_err)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #50000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 50000");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    longint unsigned due;
    longint unsigned word;
    bit              oob;
  } rd_t;

  rd_t             pend_q[$];
  logic [63:0]     m_mem [longint unsigned];
  longint unsigned cyc       = 0;
  logic            exp_valid = 1'b0;
  logic [63:0]     exp_data  = '0;
  logic            exp_known = 1'b1;
  logic [31:0]     exp_rd    = '0;
  logic [31:0]     exp_wr    = '0;
  logic [15:0]     exp_oob   = '0;
  logic            exp_perr  = 1'b0;

  logic        hold_cmp = 1'b0;
  logic        ld_req   = 1'b0;
  logic [31:0] ld_rd    = 32'hFFFF_FFFE;
  logic [31:0] ld_wr    = 32'hFFFF_FFFE;
  logic [15:0] ld_oob   = 16'hFFFD;

  function automatic bit addr_ok(input logic [63:0] a);
    return (a >= BASE) && (((a - BASE) >> 3) < 64'(DEPTH));
  endfunction

  // Transaction-level model: applies each cycle's request, answers reads LAT
  // cycles later from the model memory (which already holds this cycle's write).
  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      pend_q.delete();
      exp_valid = 1'b0;
      exp_data  = '0;
      exp_known = 1'b1;
      exp_rd    = '0;
      exp_wr    = '0;
      exp_oob   = '0;
      exp_perr  = 1'b0;
    end else begin
      longint unsigned w;
      w = (avmm_address - BASE) >> 3;
      exp_valid = 1'b0;
      if (ld_req) begin
        exp_rd  = ld_rd;
        exp_wr  = ld_wr;
        exp_oob = ld_oob;
      end
      if (avmm_write) begin
        if (exp_wr != 32'hFFFF_FFFF) exp_wr = exp_wr + 1;
        if (!addr_ok(avmm_address)) begin
          if (exp_oob != 16'hFFFF) exp_oob = exp_oob + 1;
        end else if (m_mem.exists(w) || avmm_byteenable == 8'hFF) begin
          logic [63:0] v;
          v = m_mem.exists(w) ? m_mem[w] : 64'h0;
          for (int i = 0; i < 8; i++)
            if (avmm_byteenable[i]) v[8*i +: 8] = avmm_writedata[8*i +: 8];
          m_mem[w] = v;
        end else begin
          m_mem.delete(w);
        end
        if (avmm_read) exp_perr = 1'b1;
      end else if (avmm_read) begin
        rd_t r;
        if (exp_rd != 32'hFFFF_FFFF) exp_rd = exp_rd + 1;
        r.due  = cyc + LAT - 1;
        r.word = w;
        r.oob  = !addr_ok(avmm_address);
        if (r.oob && exp_oob != 16'hFFFF) exp_oob = exp_oob + 1;
        pend_q.push_back(r);
      end
      if (pend_q.size() > 0 && pend_q[0].due == cyc) begin
        rd_t r;
        r = pend_q.pop_front();
        exp_valid = 1'b1;
        if (r.oob) begin
          exp_data  = OOB_VAL;
          exp_known = 1'b1;
        end else if (m_mem.exists(r.word)) begin
          exp_data  = m_mem[r.word];
          exp_known = 1'b1;
        end else begin
          exp_known = 1'b0;
        end
      end
      if (clear_stats) begin
        exp_rd   = '0;
        exp_wr   = '0;
        exp_oob  = '0;
        exp_perr = 1'b0;
      end
      cyc++;
    end
  end

  // Every-cycle compare, away from the active edge.
  always @(negedge clock) begin
    if (!hold_cmp) begin
      check("cyc_rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      if (exp_known) check("cyc_readdata", avmm_readdata, exp_data);
      check("cyc_rd_count", 64'(rd_count), 64'(exp_rd));
      check("cyc_wr_count", 64'(wr_count), 64'(exp_wr));
      check("cyc_oob_count", 64'(oob_count), 64'(exp_oob));
      check("cyc_proto_err", 64'(proto_err), 64'(exp_perr));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic put(input logic rd, input logic wr, input logic [63:0] addr,
                     input logic [63:0] data, input logic [7:0] be, input logic clr);
    avmm_read       = rd;
    avmm_write      = wr;
    avmm_address    = addr;
    avmm_writedata  = data;
    avmm_byteenable = be;
    clear_stats     = clr;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [63:0] addr,
                       input logic [63:0] data, input logic [7:0] be, input logic clr);
    @(posedge clock);
    #1;
    put(rd, wr, addr, data, be, clr);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0);
  endtask

  task automatic wr_word(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] be);
    drive(1'b0, 1'b1, addr, data, be, 1'b0);
  endtask

  task automatic rd_word(input logic [63:0] addr);
    drive(1'b1, 1'b0, addr, 64'h0, 8'h00, 1'b0);
  endtask

  // Idles until a response appears; lat = cycles since the last request, 0 on timeout.
  task automatic wait_rsp(output logic [63:0] d, output int lat);
    d   = '0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      idle();
      @(negedge clock);
      if (rsp_valid) begin
        d   = avmm_readdata;
        lat = k;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] d;
    int          lat;
    int          n;
    int          first_k;
    int          last_k;
    logic [63:0] got [3];

    resetn = 1'b0;
    put(1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0);
    repeat (3) @(posedge clock);
    #1 resetn = 1'b1;

    // 1: reset in the middle of read traffic
    wr_word(64'h0, 64'h0102_0304_0506_0708, 8'hFF);
    rd_word(64'h0);
    wait_rsp(d, lat);
    check("pre_reset_data", d, 64'h0102_0304_0506_0708);
    rd_word(64'h0);
    rd_word(64'h0);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    put(1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b0);
    @(negedge clock);
    check("reset_readdata", avmm_readdata, 64'h0);
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rd_count", 64'(rd_count), 64'h0);
    check("reset_wr_count", 64'(wr_count), 64'h0);
    @(posedge clock);
    #1 resetn = 1'b1;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      idle();
      @(negedge clock);
      if (rsp_valid) n++;
    end
    check("no_late_rsp", 64'(n), 64'h0);

    // 2: full write then read, latency 3
    wr_word(64'h40, 64'h1122_3344_5566_7788, 8'hFF);
    rd_word(64'h40);
    wait_rsp(d, lat);
    check("full_wr_data", d, 64'h1122_3344_5566_7788);
    check("read_latency", 64'(lat), 64'd3);

    // 3: partial write, low four lanes
    wr_word(64'h40, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F);
    rd_word(64'h44);
    wait_rsp(d, lat);
    check("partial_wr_data", d, 64'h1122_3344_BBBB_BBBB);

    // 4: back-to-back reads, then write/read-after-write ordering
    wr_word(64'h0,  64'h0000_0000_0000_00A0, 8'hFF);
    wr_word(64'h8,  64'h0000_0000_0000_00A1, 8'hFF);
    wr_word(64'h10, 64'h0000_0000_0000_00A2, 8'hFF);
    rd_word(64'h0);
    rd_word(64'h8);
    rd_word(64'h10);
    n = 0;
    first_k = 0;
    last_k = 0;
    for (int k = 1; k <= 8; k++) begin
      idle();
      @(negedge clock);
      if (rsp_valid && n < 3) begin
        got[n] = avmm_readdata;
        if (n == 0) first_k = k;
        last_k = k;
        n++;
      end
    end
    check("b2b_count", 64'(n), 64'd3);
    check("b2b_consecutive", 64'(last_k - first_k), 64'd2);
    check("b2b_data0", got[0], 64'h0000_0000_0000_00A0);
    check("b2b_data1", got[1], 64'h0000_0000_0000_00A1);
    check("b2b_data2", got[2], 64'h0000_0000_0000_00A2);
    wr_word(64'h8, 64'hCAFE_F00D_1234_5678, 8'hFF);
    rd_word(64'h8);
    wait_rsp(d, lat);
    check("raw_next_cycle", d, 64'hCAFE_F00D_1234_5678);
    // write landing in the read's exit cycle is still seen
    rd_word(64'h10);
    idle();
    wr_word(64'h10, 64'h5555_6666_7777_8888, 8'hFF);
    wait_rsp(d, lat);
    check("raw_exit_cycle", d, 64'h5555_6666_7777_8888);

    // 5: out-of-range read and write
    wr_word(64'h1F8, 64'h0BAD_C0DE_0BAD_C0DE, 8'hFF);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1);
    rd_word(64'h200);
    wr_word(64'hFFFF_FFFF_FFFF_FFF8, 64'h1234_1234_1234_1234, 8'hFF);
    wait_rsp(d, lat);
    check("oob_read_data", d, OOB_VAL);
    check("oob_count_two", 64'(oob_count), 64'd2);
    rd_word(64'h1F8);
    wait_rsp(d, lat);
    check("oob_write_dropped", d, 64'h0BAD_C0DE_0BAD_C0DE);

    // 6: read and write together, clear, saturation
    drive(1'b1, 1'b1, 64'h0, 64'h7777_0000_7777_0000, 8'hFF, 1'b0);
    n = 0;
    for (int k = 0; k < 5; k++) begin
      idle();
      @(negedge clock);
      if (rsp_valid) n++;
    end
    check("proto_no_rsp", 64'(n), 64'h0);
    check("proto_err_set", 64'(proto_err), 64'h1);
    rd_word(64'h0);
    wait_rsp(d, lat);
    check("proto_write_done", d, 64'h7777_0000_7777_0000);
    drive(1'b0, 1'b0, 64'h0, 64'h0, 8'h00, 1'b1);
    idle();
    @(negedge clock);
    check("clear_rd", 64'(rd_count), 64'h0);
    check("clear_wr", 64'(wr_count), 64'h0);
    check("clear_oob", 64'(oob_count), 64'h0);
    check("clear_proto", 64'(proto_err), 64'h0);

    @(posedge clock);
    #1;
    hold_cmp = 1'b1;
    ld_req   = 1'b1;
    force dut.rd_count_q  = 32'hFFFF_FFFE;
    force dut.wr_count_q  = 32'hFFFF_FFFE;
    force dut.oob_count_q = 16'hFFFD;
    put(1'b1, 1'b0, 64'h400, 64'h0, 8'h00, 1'b0);
    #1;
    release dut.rd_count_q;
    release dut.wr_count_q;
    release dut.oob_count_q;
    @(posedge clock);
    #1;
    ld_req   = 1'b0;
    hold_cmp = 1'b0;
    put(1'b0, 1'b1, 64'h400, 64'h0, 8'hFF, 1'b0);
    rd_word(64'h400);
    wr_word(64'h400, 64'h0, 8'hFF);
    idle();
    @(negedge clock);
    check("sat_rd", 64'(rd_count), 64'h0000_0000_FFFF_FFFF);
    check("sat_wr", 64'(wr_count), 64'h0000_0000_FFFF_FFFF);
    check("sat_oob", 64'(oob_count), 64'h0000_0000_0000_FFFF);
    repeat (5) idle();
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
